// File: rtl/hmac_sha3_pkg.sv
// Shared constants, state encoding and byte helpers for the HMAC-SHA3-256 sequencer.
package hmac_sha3_pkg;

    localparam int RATE_BITS    = 1088;
    localparam int DIGEST_BITS  = 256;
    localparam int RATE_BYTES   = 136;
    localparam int DIGEST_BYTES = 32;

    localparam logic [7:0] IPAD    = 8'h36;
    localparam logic [7:0] OPAD    = 8'h5c;
    localparam logic [7:0] SHA3_DS = 8'h06;
    localparam logic [7:0] PAD_END = 8'h80;

    // Extra padding-only block used when the message exactly fills one rate block.
    localparam logic [RATE_BITS-1:0] PAD_ONLY = {PAD_END, {(RATE_BITS-16){1'b0}}, SHA3_DS};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR_I,
        ST_I_KEY,
        ST_I_MSG,
        ST_I_PAD,
        ST_CLR_O,
        ST_O_KEY,
        ST_O_DIG,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic [RATE_BITS-1:0] key_block(input logic [RATE_BITS-1:0] k,
                                                       input logic [7:0] pad);
        return k ^ {RATE_BYTES{pad}};
    endfunction

endpackage

// File: rtl/hmac_sha3_ctrl_pad.sv
// Builds one SHA3 rate block: keeps the first len bytes of data, then applies 0x06..0x80 padding.
module sha3_block_pad
    import hmac_sha3_pkg::*;
(
    input  logic [RATE_BITS-1:0] data,
    input  logic [7:0]           len,
    input  logic                 dig_mode,
    output logic [RATE_BITS-1:0] block
);

    logic [7:0] eff_len;

    assign eff_len = dig_mode ? 8'(DIGEST_BYTES) : len;

    always_comb begin
        block = '0;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (i < int'(eff_len)) begin
                block[8*i +: 8] = data[8*i +: 8];
            end
            if (i == int'(eff_len)) begin
                block[8*i +: 8] = block[8*i +: 8] ^ SHA3_DS;
            end
        end
        // A full block carries no padding here; it goes into a separate PAD_ONLY absorb.
        if (eff_len < 8'(RATE_BYTES)) begin
            block[RATE_BITS-1 -: 8] = block[RATE_BITS-1 -: 8] ^ PAD_END;
        end
    end

endmodule

// File: rtl/hmac_sha3_ctrl.sv
// HMAC-SHA3-256 sequencer: drives a shared Keccak absorb/permute core through inner and outer hashes.
module hmac_sha3_ctrl
    import hmac_sha3_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RATE_BITS-1:0]   key,
    input  logic [RATE_BITS-1:0]   message,
    input  logic [7:0]             msg_len,
    output logic                   busy,
    output logic [DIGEST_BITS-1:0] mac_value,
    output logic                   mac_valid,
    output logic                   err,
    output logic                   core_clear,
    output logic                   core_go,
    output logic [RATE_BITS-1:0]   core_block,
    input  logic                   core_done,
    input  logic [DIGEST_BITS-1:0] core_digest
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    // Core handshake: core_go is a one-cycle request with core_block held stable until
    // core_done; core_done is honoured only in the WAIT sub-phase that follows a GO cycle.
    state_t                 state;
    logic                   wait_ph;
    logic [WD_W-1:0]        wd;
    logic [RATE_BITS-1:0]   key_r;
    logic [RATE_BITS-1:0]   msg_r;
    logic [7:0]             len_r;
    logic [DIGEST_BITS-1:0] dig_r;
    logic                   dig_mode;
    logic [RATE_BITS-1:0]   pad_data;
    logic [RATE_BITS-1:0]   pad_block;

    assign dig_mode = (state == ST_O_KEY);
    assign pad_data = dig_mode ? {{(RATE_BITS-DIGEST_BITS){1'b0}}, dig_r} : msg_r;

    sha3_block_pad u_pad (
        .data     (pad_data),
        .len      (len_r),
        .dig_mode (dig_mode),
        .block    (pad_block)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_ph    <= 1'b0;
            wd         <= '0;
            key_r      <= '0;
            msg_r      <= '0;
            len_r      <= '0;
            dig_r      <= '0;
            busy       <= 1'b0;
            mac_value  <= '0;
            mac_valid  <= 1'b0;
            err        <= 1'b0;
            core_clear <= 1'b0;
            core_go    <= 1'b0;
            core_block <= '0;
        end else begin
            core_clear <= 1'b0;
            core_go    <= 1'b0;
            mac_valid  <= 1'b0;
            case (state)
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        key_r      <= key;
                        msg_r      <= message;
                        len_r      <= (msg_len > 8'(RATE_BYTES)) ? 8'(RATE_BYTES) : msg_len;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        core_clear <= 1'b1;
                        state      <= ST_CLR_I;
                    end
                end
                ST_CLR_I: begin
                    state      <= ST_I_KEY;
                    wait_ph    <= 1'b0;
                    core_go    <= 1'b1;
                    core_block <= key_block(key_r, IPAD);
                end
                ST_CLR_O: begin
                    state      <= ST_O_KEY;
                    wait_ph    <= 1'b0;
                    core_go    <= 1'b1;
                    core_block <= key_block(key_r, OPAD);
                end
                ST_I_KEY, ST_I_MSG, ST_I_PAD, ST_O_KEY, ST_O_DIG: begin
                    if (!wait_ph) begin
                        wait_ph <= 1'b1;
                        wd      <= WD_W'(1);
                    end else if (core_done) begin
                        wait_ph <= 1'b0;
                        case (state)
                            ST_I_KEY: begin
                                state      <= ST_I_MSG;
                                core_go    <= 1'b1;
                                core_block <= pad_block;
                            end
                            ST_I_MSG: begin
                                dig_r <= core_digest;
                                if (len_r == 8'(RATE_BYTES)) begin
                                    state      <= ST_I_PAD;
                                    core_go    <= 1'b1;
                                    core_block <= PAD_ONLY;
                                end else begin
                                    state      <= ST_CLR_O;
                                    core_clear <= 1'b1;
                                end
                            end
                            ST_I_PAD: begin
                                dig_r      <= core_digest;
                                state      <= ST_CLR_O;
                                core_clear <= 1'b1;
                            end
                            ST_O_KEY: begin
                                state      <= ST_O_DIG;
                                core_go    <= 1'b1;
                                core_block <= pad_block;
                            end
                            default: begin
                                mac_value <= core_digest;
                                mac_valid <= 1'b1;
                                busy      <= 1'b0;
                                state     <= ST_DONE;
                            end
                        endcase
                    end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                        wait_ph <= 1'b0;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_ERR;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
